// File: rtl/dac_out_ctrl.sv
// DAC output stage: slot-timed sample hold, gain/offset, soft mute ramp,
// saturation and DAC code conversion with a registered output bus.
module dac_out_ctrl #(
    parameter int DATA_W = 14,
    parameter int GAIN_W = 16,
    parameter int RAMP_W = 4,
    parameter int HOLD   = 4,
    parameter int OBIN   = 1,
    parameter int UCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              enable,
    input  logic [GAIN_W-1:0] gain,
    input  logic [DATA_W-1:0] offset,
    input  logic              underflow_clr,
    output logic [DATA_W-1:0] dac_data,
    output logic              muted,
    output logic [UCNT_W-1:0] underflow_cnt
);

    localparam int PW = DATA_W + GAIN_W + 1;
    localparam int QW = PW + RAMP_W + 2;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [HW-1:0]     HLAST = HW'(HOLD - 1);
    localparam logic [RAMP_W:0]   RMAX  = {1'b1, {RAMP_W{1'b0}}};
    localparam logic [RAMP_W:0]   RLAST = RMAX - 1'b1;
    localparam logic [RAMP_W:0]   RONE  = {{RAMP_W{1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] MID   = (OBIN != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : '0;
    localparam logic signed [QW-1:0] QMAX = {{(QW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [QW-1:0] QMIN = {{(QW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        MUTED,
        RAMP_UP,
        ACTIVE,
        RAMP_DOWN
    } state_t;

    state_t             r_state;
    logic [RAMP_W:0]    r_ramp;
    logic [HW-1:0]      r_hold_cnt;
    logic [DATA_W-1:0]  r_sample;
    logic [UCNT_W-1:0]  r_ucnt;
    logic signed [PW-1:0] r_p;
    logic [DATA_W-1:0]  r_q;
    logic [DATA_W-1:0]  r_dac;

    logic                 w_slot_end;
    logic signed [PW-1:0] w_sx;
    logic signed [PW-1:0] w_gx;
    logic signed [PW-1:0] w_off;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_p;
    logic signed [QW-1:0] w_px;
    logic signed [QW-1:0] w_rx;
    logic signed [QW-1:0] w_pr;
    logic signed [QW-1:0] w_sh;
    logic [DATA_W-1:0]    w_q;

    assign w_slot_end    = (r_hold_cnt == HLAST);
    assign in_ready      = w_slot_end;
    assign muted         = (r_state == MUTED);
    assign underflow_cnt = r_ucnt;
    assign dac_data      = r_dac;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_cnt <= '0;
        end else if (w_slot_end) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
        end
    end

    // A missed slot keeps the previous sample; only counted once audio is live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample <= '0;
            r_ucnt   <= '0;
        end else begin
            if (w_slot_end && in_valid) begin
                r_sample <= in_data;
            end
            if (underflow_clr) begin
                r_ucnt <= '0;
            end else if (w_slot_end && !in_valid && (r_state != MUTED) && (r_ucnt != '1)) begin
                r_ucnt <= r_ucnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MUTED;
            r_ramp  <= '0;
        end else begin
            case (r_state)
                MUTED: begin
                    if (enable) begin
                        r_ramp  <= RONE;
                        r_state <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (!enable) begin
                        r_ramp  <= r_ramp - 1'b1;
                        r_state <= (r_ramp == RONE) ? MUTED : RAMP_DOWN;
                    end else begin
                        r_ramp  <= r_ramp + 1'b1;
                        if (r_ramp == RLAST) r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (!enable) begin
                        r_ramp  <= RLAST;
                        r_state <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (enable) begin
                        r_ramp  <= r_ramp + 1'b1;
                        r_state <= (r_ramp == RLAST) ? ACTIVE : RAMP_UP;
                    end else begin
                        r_ramp  <= r_ramp - 1'b1;
                        if (r_ramp == RONE) r_state <= MUTED;
                    end
                end
                default: begin
                    r_state <= MUTED;
                    r_ramp  <= '0;
                end
            endcase
        end
    end

    assign w_sx   = {{(PW-DATA_W){r_sample[DATA_W-1]}}, r_sample};
    assign w_gx   = {{(PW-GAIN_W){1'b0}}, gain};
    assign w_off  = {{(PW-DATA_W){offset[DATA_W-1]}}, offset};
    assign w_prod = w_sx * w_gx;
    assign w_p    = (w_prod >>> (GAIN_W - 1)) + w_off;

    // Offset is inside the ramp product so r=0 always lands on exact midscale.
    assign w_px = {{(QW-PW){r_p[PW-1]}}, r_p};
    assign w_rx = {{(QW-RAMP_W-1){1'b0}}, r_ramp};
    assign w_pr = w_px * w_rx;
    assign w_sh = w_pr >>> RAMP_W;

    always_comb begin
        w_q = w_sh[DATA_W-1:0];
        if (w_sh > QMAX) begin
            w_q = QMAX[DATA_W-1:0];
        end else if (w_sh < QMIN) begin
            w_q = QMIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p   <= '0;
            r_q   <= '0;
            r_dac <= MID;
        end else begin
            r_p <= w_p;
            r_q <= w_q;
            if (OBIN != 0) begin
                r_dac <= {~r_q[DATA_W-1], r_q[DATA_W-2:0]};
            end else begin
                r_dac <= r_q;
            end
        end
    end

endmodule

// File: tb/tb_dac_out_ctrl.sv
// Self-checking bench for dac_out_ctrl: vector table in ACTIVE plus ramp,
// underflow and reset sequences, expected codes queued and popped on output.
module tb_dac_out_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] gain = '0;
    logic [13:0] offset = '0;
    logic        underflow_clr = 1'b0;

    logic [13:0] dac_data, dac_data_s;
    logic        in_ready, in_ready_s;
    logic        muted, muted_s;
    logic [15:0] ucnt;
    logic [1:0]  ucnt_s;

    int n_pass = 0;
    int n_total = 0;
    int r_m = 0;
    logic [13:0] exp_q[$];

    typedef struct packed {
        logic [13:0] d;
        logic [15:0] g;
        logic [13:0] o;
        logic [13:0] e;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    dac_out_ctrl #(.DATA_W(14), .GAIN_W(16), .RAMP_W(4), .HOLD(4), .OBIN(1), .UCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .enable(enable), .gain(gain), .offset(offset), .underflow_clr(underflow_clr),
        .dac_data(dac_data), .muted(muted), .underflow_cnt(ucnt)
    );

    dac_out_ctrl #(.DATA_W(14), .GAIN_W(16), .RAMP_W(4), .HOLD(4), .OBIN(1), .UCNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_s),
        .enable(enable), .gain(gain), .offset(offset), .underflow_clr(underflow_clr),
        .dac_data(dac_data_s), .muted(muted_s), .underflow_cnt(ucnt_s)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [13:0] model_code(input logic [13:0] s, input logic [15:0] g,
                                               input logic [13:0] o, input int r);
        longint p, q;
        p = (longint'($signed(s)) * longint'(g)) >>> 15;
        p = p + longint'($signed(o));
        q = (p * longint'(r)) >>> 4;
        if (q > 8191) q = 8191;
        if (q < -8192) q = -8192;
        return 14'(q) ^ 14'h2000;
    endfunction

    task automatic wait_slot_end();
        bit found = 0;
        for (int i = 0; i < 8; i++) begin
            if (in_ready) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        if (!found) check("in_ready_timeout", 0, 1);
    endtask

    task automatic ramp_begin();
        exp_q.delete();
        exp_q.push_back(model_code(in_data, gain, offset, r_m));
        exp_q.push_back(model_code(in_data, gain, offset, r_m));
    endtask

    // Ramp model: one step per clock toward the enable target; output lags r by two clocks.
    task automatic ramp_run(input bit en, input int n, input bit mono);
        logic [13:0] prev, e;
        enable = en;
        prev = dac_data;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (en) r_m = (r_m < 16) ? r_m + 1 : 16;
            else    r_m = (r_m > 0) ? r_m - 1 : 0;
            exp_q.push_back(model_code(in_data, gain, offset, r_m));
            @(negedge clk);
            if (exp_q.size() >= 3) begin
                e = exp_q.pop_front();
                check("ramp_code", dac_data, e);
            end
            if (mono) check("ramp_monotonic", (dac_data >= prev), 1);
            prev = dac_data;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] e;

        vecs[0] = '{14'h0100, 16'h8000, 14'h0000, 14'h2100};
        vecs[1] = '{14'h1FFF, 16'hFFFF, 14'h0000, 14'h3FFF};
        vecs[2] = '{14'h2000, 16'hFFFF, 14'h0000, 14'h0000};
        vecs[3] = '{14'h0000, 16'h8000, 14'h0100, 14'h2100};
        vecs[4] = '{14'h0001, 16'h4000, 14'h0000, 14'h2000};
        vecs[5] = '{14'h3FFF, 16'h4000, 14'h0000, 14'h1FFF};
        vecs[6] = '{14'h3F00, 16'h4000, 14'h0000, 14'h1F80};
        vecs[7] = '{14'h1000, 16'h8000, 14'h1000, 14'h3FFF};
        vecs[8] = '{14'h3000, 16'h8000, 14'h2FFF, 14'h0000};
        vecs[9] = '{14'h1000, 16'h8000, 14'h0FFF, 14'h3FFF};
        for (int i = 10; i < 16; i++) begin
            vecs[i].d = 14'($urandom);
            vecs[i].g = 16'($urandom);
            vecs[i].o = 14'($urandom);
            vecs[i].e = model_code(vecs[i].d, vecs[i].g, vecs[i].o, 16);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dac", dac_data, 14'h2000);
        check("rst_muted", muted, 1);
        check("rst_ucnt", ucnt, 0);
        check("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check("in_ready_period", in_ready, ((k % 4) == 3));
        end
        check("idle_dac", dac_data, 14'h2000);
        check("idle_muted", muted, 1);

        // Missed slots while muted are not underflows
        repeat (8) @(negedge clk);
        check("muted_no_underflow", ucnt, 0);
        check("muted_no_underflow_s", ucnt_s, 0);

        // Sample loaded while muted, then ramp up
        in_data = 14'h0100; in_valid = 1'b1; gain = 16'h8000; offset = '0;
        repeat (8) @(negedge clk);
        check("muted_midscale", dac_data, 14'h2000);
        r_m = 0;
        ramp_begin();
        ramp_run(1, 20, 1);
        check("active_muted", muted, 0);
        check("active_dac", dac_data, 14'h2100);

        // Vector table in ACTIVE
        for (int i = 0; i < 16; i++) begin
            in_data = vecs[i].d; gain = vecs[i].g; offset = vecs[i].o;
            exp_q.delete();
            exp_q.push_back(vecs[i].e);
            repeat (12) @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("vec%0d", i), dac_data, e);
        end
        in_data = 14'h0100; gain = 16'h8000; offset = '0;
        repeat (12) @(negedge clk);
        check("restore_dac", dac_data, 14'h2100);

        // Underflow: 3 missed slots, then 2 more (narrow counter saturates)
        wait_slot_end();
        in_data = 14'h0200; in_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("uf_cnt3", ucnt, 3);
        check("uf_cnt3_s", ucnt_s, 3);
        check("uf_hold_dac", dac_data, 14'h2100);
        repeat (8) @(negedge clk);
        check("uf_cnt5", ucnt, 5);
        check("uf_sat_s", ucnt_s, 3);
        check("uf_in_ready", in_ready, 1);
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        check("uf_clr_wins", ucnt, 0);
        check("uf_clr_wins_s", ucnt_s, 0);
        repeat (4) @(negedge clk);
        check("uf_recount", ucnt, 1);
        in_valid = 1'b1;
        underflow_clr = 1'b1;
        @(negedge clk);
        underflow_clr = 1'b0;
        check("uf_clr", ucnt, 0);
        repeat (8) @(negedge clk);
        check("uf_resume_dac", dac_data, 14'h2200);

        // Ramp down, partial up, reversal at r=8
        r_m = 16;
        ramp_begin();
        ramp_run(0, 20, 0);
        check("down_muted", muted, 1);
        ramp_run(1, 8, 0);
        ramp_run(0, 7, 0);
        check("rev_not_yet_muted", muted, 0);
        ramp_run(0, 1, 0);
        check("rev_muted", muted, 1);
        ramp_run(0, 3, 0);
        check("rev_dac_mid", dac_data, 14'h2000);
        ramp_run(1, 20, 0);
        ramp_run(0, 5, 0);
        ramp_run(1, 3, 0);
        ramp_run(1, 10, 0);
        check("reup_dac", dac_data, 14'h2200);

        // Async reset mid ramp-down
        wait_slot_end();
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        check("pre_rst_ucnt", ucnt, 1);
        r_m = 16;
        ramp_begin();
        ramp_run(0, 4, 0);
        check("pre_rst_muted", muted, 0);
        rst_n = 1'b0;
        #1;
        check("arst_dac", dac_data, 14'h2000);
        check("arst_muted", muted, 1);
        check("arst_ucnt", ucnt, 0);
        check("arst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_dac", dac_data, 14'h2000);
        check("post_rst_muted", muted, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
